// File: rtl/serial_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, the running
// decision, and the decision-to-{Y2,Y1,Y0} encoding used by the parallel comparators.
package serial_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EQ = 2'd0,
      LT = 2'd1,
      GT = 2'd2
   } decision_t;

   // {Y2,Y1,Y0} = {A>B, A==B, A<B}; exactly one bit set for any legal decision
   function automatic logic [2:0] decision_to_y(input decision_t d);
      case (d)
         GT:      decision_to_y = 3'b100;
         LT:      decision_to_y = 3'b001;
         default: decision_to_y = 3'b010;
      endcase
   endfunction

endpackage

// File: rtl/serial_comparator_cmp_bit_cell.sv
// One MSB-first comparison step: the first differing bit pair resolves the decision,
// after which the decision is sticky.
module cmp_bit_cell
   import serial_comparator_pkg::*;
(
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic [1:0] decision_in,
   output logic [1:0] decision_out
);

   always_comb begin
      decision_out = decision_in;
      if ((decision_in == EQ) && (a_bit != b_bit)) begin
         decision_out = a_bit ? GT : LT;
      end
   end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first over a valid/ready handshake.
// Optional SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first beat that resolves LT/GT.
module serial_comparator
   import serial_comparator_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_vld,
   input  logic a_bit,
   input  logic b_bit,
   output logic in_rdy,
   output logic busy,
   output logic out_vld,
   output logic Y0,
   output logic Y1,
   output logic Y2
);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] cnt_next;
   decision_t        decision;
   decision_t        cell_decision;
   logic [1:0]       cell_out;
   logic [2:0]       y_reg;
   logic             beat;
   logic             last_beat;
   logic             resolved;
   logic             finish;

   cmp_bit_cell u_cell (
      .a_bit        (a_bit),
      .b_bit        (b_bit),
      .decision_in  (decision),
      .decision_out (cell_out)
   );

   assign cell_decision = decision_t'(cell_out);
   assign beat          = (state == SHIFT) && in_vld;
   assign cnt_next      = counter + CNT_W'(1);
   assign last_beat     = (cnt_next == CNT_W'(WIDTH));

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
   // Decision can only leave EQ on the beat that resolves it, so this fires once
   assign resolved = (cell_decision != EQ);
`else
   assign resolved = 1'b0;
`endif

   assign finish = beat && (last_beat || resolved);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)  next_state = SHIFT;
         SHIFT:   if (finish) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Result is captured on the finishing beat so it is visible alongside out_vld in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter  <= '0;
         decision <= EQ;
         y_reg    <= 3'b000;
      end else begin
         if ((state == IDLE) && start) begin
            counter  <= '0;
            decision <= EQ;
         end
         if (beat) begin
            counter  <= cnt_next;
            decision <= cell_decision;
         end
         if (finish) begin
            y_reg <= decision_to_y(cell_decision);
         end
      end
   end

   assign in_rdy  = (state == SHIFT);
   assign busy    = (state != IDLE);
   assign out_vld = (state == DONE);
   assign Y2      = y_reg[2];
   assign Y1      = y_reg[1];
   assign Y0      = y_reg[0];

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (WIDTH=4): vector table plus hand-written
// sequences for stalls, ignored starts and reset mid-transaction.
module tb_serial_comparator;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic in_vld;
   logic a_bit;
   logic b_bit;
   logic in_rdy;
   logic busy;
   logic out_vld;
   logic Y0;
   logic Y1;
   logic Y2;

   int checks = 0;
   int errors = 0;

   serial_comparator #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_vld  (in_vld),
      .a_bit   (a_bit),
      .b_bit   (b_bit),
      .in_rdy  (in_rdy),
      .busy    (busy),
      .out_vld (out_vld),
      .Y0      (Y0),
      .Y1      (Y1),
      .Y2      (Y2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] y;
      int         lat;
      int         lat_early;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int pick_lat(input int lat, input int lat_early);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
      return lat_early;
`else
      return lat;
`endif
   endfunction

   // Cycle 0 carries start; bits are offered whenever in_rdy is high. A start is
   // also driven during the out_vld cycle and must be ignored.
   task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int gap_after,
                          input int gaps, input int restart_cycle,
                          output logic [2:0] y, output int lat, output int beats);
      int cycle;
      int gaps_left;
      @(posedge clk); #1;
      start = 1'b1; in_vld = 1'b0; cycle = 0; beats = 0; lat = -1; y = 3'b000;
      gaps_left = gaps;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cycle++;
         start = (cycle == restart_cycle);
         if (out_vld) begin
            lat = cycle;
            y = {Y2, Y1, Y0};
            check("in_rdy_at_out_vld", {31'd0, in_rdy}, 32'd0);
            in_vld = 1'b0;
            start = 1'b1;
            break;
         end
         if (in_rdy && beats < 4 && !(beats == gap_after && gaps_left > 0)) begin
            in_vld = 1'b1;
            a_bit = a[3 - beats];
            b_bit = b[3 - beats];
            beats++;
         end else begin
            in_vld = 1'b0;
            if (in_rdy && beats == gap_after && gaps_left > 0) gaps_left--;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=no_out_vld required=out_vld");
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("out_vld_one_cycle", {31'd0, out_vld}, 32'd0);
      check("start_in_done_ignored", {31'd0, busy}, 32'd0);
      check("y_held", {29'd0, Y2, Y1, Y0}, {29'd0, y});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [2:0] y;
      int lat;
      int beats;
      int pulses;
      int exp_lat;

      vecs[0] = '{a: 4'b0101, b: 4'b0011, y: 3'b100, lat: 5, lat_early: 3};
      vecs[1] = '{a: 4'b1010, b: 4'b1010, y: 3'b010, lat: 5, lat_early: 5};
      vecs[2] = '{a: 4'b0000, b: 4'b1111, y: 3'b001, lat: 5, lat_early: 2};
      vecs[3] = '{a: 4'b1111, b: 4'b1111, y: 3'b010, lat: 5, lat_early: 5};
      vecs[4] = '{a: 4'b1000, b: 4'b0111, y: 3'b100, lat: 5, lat_early: 2};
      vecs[5] = '{a: 4'b0110, b: 4'b0111, y: 3'b001, lat: 5, lat_early: 5};
      vecs[6] = '{a: 4'b0001, b: 4'b0010, y: 3'b001, lat: 5, lat_early: 4};
      vecs[7] = '{a: 4'b1001, b: 4'b1000, y: 3'b100, lat: 5, lat_early: 5};

      rst = 1'b1; start = 1'b0; in_vld = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_y", {29'd0, Y2, Y1, Y0}, 32'd0);
      check("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_out_vld", {31'd0, out_vld}, 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) begin
         run_txn(vecs[k].a, vecs[k].b, -1, 0, -1, y, lat, beats);
         exp_lat = pick_lat(vecs[k].lat, vecs[k].lat_early);
         check($sformatf("vec%0d_y", k), {29'd0, y}, {29'd0, vecs[k].y});
         check($sformatf("vec%0d_latency", k), lat, exp_lat);
         check($sformatf("vec%0d_beats", k), beats, exp_lat - 1);
      end

      // Three-cycle stall between beats 2 and 3
      run_txn(4'b1100, 4'b1011, 2, 3, -1, y, lat, beats);
      check("stall_y", {29'd0, y}, 32'b100);
      check("stall_latency", lat, pick_lat(8, 3));

      // Second start pulse at cycle 2 must not restart the transaction
      run_txn(4'b0101, 4'b0011, -1, 0, 2, y, lat, beats);
      check("restart_y", {29'd0, y}, 32'b100);
      check("restart_latency", lat, pick_lat(5, 3));

      // Reset after beat 2 of an unresolved transaction (Y currently holds GT)
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; in_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
      @(posedge clk); #1;
      a_bit = 1'b0; b_bit = 1'b0;
      @(posedge clk); #1;
      in_vld = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_y", {29'd0, Y2, Y1, Y0}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_in_rdy", {31'd0, in_rdy}, 32'd0);
      check("midrst_out_vld", {31'd0, out_vld}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_vld) pulses++;
      end
      check("midrst_no_out_vld", pulses, 0);

      run_txn(4'b0001, 4'b0010, -1, 0, -1, y, lat, beats);
      check("after_rst_y", {29'd0, y}, 32'b001);
      check("after_rst_latency", lat, pick_lat(5, 4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
